// File: rtl/apb_clk_gate_pkg.sv
// ---------------------------------------------------------------------------
// apb_clk_gate_pkg
// Shared types and constants for the APB clock-gate controller:
//   - ch_state_e     : per-channel gating state (ON / IDLE / OFF)
//   - ADDR_*         : register byte offsets (PADDR[4:2] decode)
//   - TIMEOUT_RST    : reset value of the idle-timeout register
// ---------------------------------------------------------------------------
package apb_clk_gate_pkg;

  typedef enum logic [1:0] {
    CH_ON   = 2'd0,
    CH_IDLE = 2'd1,
    CH_OFF  = 2'd2
  } ch_state_e;

  localparam logic [4:0] ADDR_CTRL      = 5'h00;
  localparam logic [4:0] ADDR_AUTO      = 5'h04;
  localparam logic [4:0] ADDR_STATUS    = 5'h08;
  localparam logic [4:0] ADDR_TIMEOUT   = 5'h0C;
  localparam logic [4:0] ADDR_WAKE_PEND = 5'h10;
  localparam logic [4:0] ADDR_IRQ_MASK  = 5'h14;
  // First offset with no register behind it; everything from here up errors.
  localparam logic [4:0] ADDR_UNMAPPED  = 5'h18;

  localparam logic [31:0] TIMEOUT_RST = 32'h0000_00FF;

endpackage

// File: rtl/apb_clk_gate_ctrl_if.sv
// ---------------------------------------------------------------------------
// apb_clk_gate_ctrl_if
// APB3 slave bus bundle for the clock-gate controller.
//   PADDR/PWDATA/PWRITE/PSEL/PENABLE : master -> slave
//   PRDATA/PREADY/PSLVERR            : slave  -> master
// Modports: master (bus driver / testbench), slave (the controller).
// ---------------------------------------------------------------------------
interface apb_clk_gate_ctrl_if #(
  parameter int APB_ADDR_WIDTH = 12
);
  logic [APB_ADDR_WIDTH-1:0] PADDR;
  logic [31:0]               PWDATA;
  logic                      PWRITE;
  logic                      PSEL;
  logic                      PENABLE;
  logic [31:0]               PRDATA;
  logic                      PREADY;
  logic                      PSLVERR;

  modport master (
    output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/clk_gate_ch_fsm.sv
// ---------------------------------------------------------------------------
// clk_gate_ch_fsm
// One channel of the clock-gate controller: ON/IDLE/OFF state machine with
// its idle-timeout down-counter.
// Ports:
//   clk, rst_n   : system clock, asynchronous active-low reset
//   ctrl_i       : manual enable bit for this channel
//   auto_i       : auto-gate enable bit for this channel
//   busy_i       : peripheral busy (holds the clock on while ON/IDLE)
//   wake_i       : wake event level
//   timeout_i    : idle cycles loaded on ON -> IDLE
//   clk_en_o     : registered clock enable (1 in ON and IDLE)
//   wake_set_o   : one-cycle request to set this channel's pending wake bit
// ---------------------------------------------------------------------------
module clk_gate_ch_fsm
  import apb_clk_gate_pkg::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ctrl_i,
  input  logic                 auto_i,
  input  logic                 busy_i,
  input  logic                 wake_i,
  input  logic [CNT_WIDTH-1:0] timeout_i,
  output logic                 clk_en_o,
  output logic                 wake_set_o
);

  ch_state_e            state_reg, state_next;
  logic [CNT_WIDTH-1:0] cnt_reg, cnt_next;
  logic                 clk_en_reg, clk_en_next;

  // State register. The enable is a flop of its own so the gating cell sees
  // a clean registered level that changes on the same edge as the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= CH_ON;
      cnt_reg    <= '0;
      clk_en_reg <= 1'b1;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      clk_en_reg <= clk_en_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      CH_ON: begin
        // Busy keeps the clock running until the peripheral has drained.
        if (!ctrl_i && !busy_i) begin
          state_next = auto_i ? CH_IDLE : CH_OFF;
        end
      end
      CH_IDLE: begin
        if (ctrl_i || busy_i) begin
          state_next = CH_ON;
        end else if (!auto_i) begin
          // Auto-gating withdrawn mid-countdown: gate right away.
          state_next = CH_OFF;
        end else if (wake_i) begin
          state_next = CH_ON;
        end else if (cnt_reg == '0) begin
          state_next = CH_OFF;
        end
      end
      CH_OFF: begin
        // Busy is deliberately not looked at: the peripheral has no clock.
        if (ctrl_i || (auto_i && wake_i)) begin
          state_next = CH_ON;
        end
      end
      default: state_next = CH_ON;
    endcase
  end

  // Output / datapath logic
  always_comb begin
    cnt_next = cnt_reg;
    if (state_reg == CH_ON && state_next == CH_IDLE) begin
      cnt_next = timeout_i;
    end else if (state_reg == CH_IDLE && state_next == CH_IDLE) begin
      // Staying in IDLE implies the count is non-zero, so this never wraps.
      cnt_next = cnt_reg - CNT_WIDTH'(1);
    end
    clk_en_next = (state_next != CH_OFF);
    // Only an automatic wake out of OFF is reported; a manual enable is not.
    wake_set_o  = (state_reg == CH_OFF) && !ctrl_i && auto_i && wake_i;
  end

  assign clk_en_o = clk_en_reg;

endmodule

// File: rtl/apb_clk_gate_ctrl.sv
// ---------------------------------------------------------------------------
// apb_clk_gate_ctrl
// APB-programmable clock-gate controller for NUM_CH peripheral channels with
// busy-aware draining and idle-timeout auto-gating with wake-up.
// Ports:
//   clk, rst_n   : ungated system clock, asynchronous active-low reset
//   apb          : APB slave port (apb_clk_gate_ctrl_if.slave)
//   ch_busy_i    : per-channel peripheral busy
//   ch_wake_i    : per-channel wake event (level)
//   clk_en_o     : per-channel registered clock enable
//   irq_o        : wake interrupt (level)
// Registers (byte offsets): 0x00 CTRL, 0x04 AUTO, 0x08 STATUS, 0x0C TIMEOUT,
//   0x10 WAKE_PEND (W1C), 0x14 IRQ_MASK; 0x18/0x1C respond with PSLVERR.
// Build option: define APB_CLK_GATE_WAKE_IRQ_EN to implement WAKE_PEND,
//   IRQ_MASK and irq_o; otherwise those offsets read 0 and irq_o is 0.
// ---------------------------------------------------------------------------
module apb_clk_gate_ctrl
  import apb_clk_gate_pkg::*;
#(
  parameter int NUM_CH         = 8,
  parameter int CNT_WIDTH      = 16,
  parameter int APB_ADDR_WIDTH = 12
) (
  input  logic                clk,
  input  logic                rst_n,
  apb_clk_gate_ctrl_if.slave  apb,
  input  logic [NUM_CH-1:0]   ch_busy_i,
  input  logic [NUM_CH-1:0]   ch_wake_i,
  output logic [NUM_CH-1:0]   clk_en_o,
  output logic                irq_o
);

  logic [APB_ADDR_WIDTH-1:0] paddr;
  logic [4:0]                reg_off;
  logic                      access;
  logic                      unmapped;
  logic                      wr_en;
  logic [NUM_CH-1:0]         wdata_ch;

  logic [NUM_CH-1:0]         ctrl_reg;
  logic [NUM_CH-1:0]         auto_reg;
  logic [CNT_WIDTH-1:0]      timeout_reg;
  logic [NUM_CH-1:0]         wake_set;
  logic [NUM_CH-1:0]         wake_pend_rd;
  logic [NUM_CH-1:0]         irq_mask_rd;
  logic [31:0]               rd_data;

  // Only PADDR[4:2] selects a register; the rest of the address and the
  // write-data bits above the field widths are don't-care.
  logic unused_apb;
  assign unused_apb = ^{paddr, apb.PWDATA};

  assign paddr    = apb.PADDR;
  assign reg_off  = {paddr[4:2], 2'b00};
  assign access   = apb.PSEL & apb.PENABLE;
  assign unmapped = (reg_off >= ADDR_UNMAPPED);
  assign wr_en    = access & apb.PWRITE & ~unmapped;
  assign wdata_ch = apb.PWDATA[NUM_CH-1:0];

  assign apb.PREADY  = 1'b1;
  assign apb.PSLVERR = access & unmapped;

  // Control registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_reg    <= '1;
      auto_reg    <= '0;
      timeout_reg <= CNT_WIDTH'(TIMEOUT_RST);
    end else if (wr_en) begin
      case (reg_off)
        ADDR_CTRL:    ctrl_reg    <= wdata_ch;
        ADDR_AUTO:    auto_reg    <= wdata_ch;
        ADDR_TIMEOUT: timeout_reg <= apb.PWDATA[CNT_WIDTH-1:0];
        default: ;
      endcase
    end
  end

  // Per-channel state machines
  genvar gi;
  for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
    clk_gate_ch_fsm #(
      .CNT_WIDTH (CNT_WIDTH)
    ) u_fsm (
      .clk        (clk),
      .rst_n      (rst_n),
      .ctrl_i     (ctrl_reg[gi]),
      .auto_i     (auto_reg[gi]),
      .busy_i     (ch_busy_i[gi]),
      .wake_i     (ch_wake_i[gi]),
      .timeout_i  (timeout_reg),
      .clk_en_o   (clk_en_o[gi]),
      .wake_set_o (wake_set[gi])
    );
  end

`ifdef APB_CLK_GATE_WAKE_IRQ_EN
  logic [NUM_CH-1:0] wake_pend_reg, wake_pend_next;
  logic [NUM_CH-1:0] irq_mask_reg;
  logic              irq_reg;

  always_comb begin
    wake_pend_next = wake_pend_reg;
    if (wr_en && reg_off == ADDR_WAKE_PEND) begin
      wake_pend_next = wake_pend_reg & ~wdata_ch;
    end
    // Applied after the clear so a wake on the same edge is never lost.
    wake_pend_next = wake_pend_next | wake_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wake_pend_reg <= '0;
      irq_mask_reg  <= '0;
      irq_reg       <= 1'b0;
    end else begin
      wake_pend_reg <= wake_pend_next;
      if (wr_en && reg_off == ADDR_IRQ_MASK) begin
        irq_mask_reg <= wdata_ch;
      end
      irq_reg <= |(wake_pend_reg & irq_mask_reg);
    end
  end

  assign wake_pend_rd = wake_pend_reg;
  assign irq_mask_rd  = irq_mask_reg;
  assign irq_o        = irq_reg;
`else
  logic unused_wake_set;
  assign unused_wake_set = ^wake_set;
  assign wake_pend_rd    = '0;
  assign irq_mask_rd     = '0;
  assign irq_o           = 1'b0;
`endif

  // Read mux: combinational, driven only while selected.
  always_comb begin
    rd_data = '0;
    if (apb.PSEL) begin
      case (reg_off)
        ADDR_CTRL:      rd_data = 32'(ctrl_reg);
        ADDR_AUTO:      rd_data = 32'(auto_reg);
        ADDR_STATUS:    rd_data = 32'(clk_en_o);
        ADDR_TIMEOUT:   rd_data = 32'(timeout_reg);
        ADDR_WAKE_PEND: rd_data = 32'(wake_pend_rd);
        ADDR_IRQ_MASK:  rd_data = 32'(irq_mask_rd);
        default:        rd_data = '0;
      endcase
    end
  end

  assign apb.PRDATA = rd_data;

endmodule

// File: doc/apb_clk_gate_ctrl.md
# apb_clk_gate_ctrl

Parametrised APB peripheral clock-gate controller. It is the successor to the fixed 8-bit clock-gate register that drives the peripheral subsystem's cluster_clock_gating cells. It drives NUM_CH clock-enable outputs, each from its own per-channel state machine, and adds two behaviours the fixed register lacks:
- busy-aware draining: a channel is never gated while its peripheral reports busy;
- automatic idle-timeout gating with event wake-up.

It sits on one APB slave port of periph_bus_wrap, and its clk_en_o bits feed the en_i inputs of the per-peripheral gating cells.

## Interface
- NUM_CH, default 8: number of gated channels, 1..32.
- CNT_WIDTH, default 16: width of the idle-timeout counter and the TIMEOUT register field.
- APB_ADDR_WIDTH, default 12: PADDR width.

Ports:
- clk  in  1  single clock (ungated system clock).
- rst_n  in  1  asynchronous active-low reset.
- PADDR  in  APB_ADDR_WIDTH  APB address; bits [4:2] decode the register.
- PWDATA  in  32  APB write data.
- PWRITE  in  1  APB write strobe.
- PSEL  in  1  APB select.
- PENABLE  in  1  APB enable.
- PRDATA  out  32  APB read data.
- PREADY  out  1  tied to 1.
- PSLVERR  out  1  error response for an unmapped offset.
- ch_busy_i  in  NUM_CH  per-channel peripheral busy.
- ch_wake_i  in  NUM_CH  per-channel wake event; level, sampled every cycle.
- clk_en_o  out  NUM_CH  registered clock-enable per channel.
- irq_o  out  1  wake interrupt (level).

## Operation
Registers (unused upper bits read 0; NUM_CH-wide fields use the low bits):
- 0x00 CTRL: manual enable, RW, reset all ones.
- 0x04 AUTO: auto-gate mask, RW, reset 0.
- 0x08 STATUS: clk_en_o, RO.
- 0x0C TIMEOUT: RW, CNT_WIDTH bits, reset 0x00FF.
- 0x10 WAKE_PEND: W1C.
- 0x14 IRQ_MASK: RW, reset 0.

APB access rules:
- A write commits when PSEL&PENABLE&PWRITE.
- A read returns the current register value combinationally.
- Offsets 0x18..0x1C assert PSLVERR during the access phase, write nothing and read 0.

Per-channel FSM, states ON, IDLE, OFF; reset state ON:
- ON
  - If CTRL[i]=1, stay in ON.
  - Else if ch_busy_i[i]=1, stay in ON (drain).
  - Else if AUTO[i]=1, go to IDLE and load the counter with TIMEOUT.
  - Otherwise go to OFF.
- IDLE
  - If CTRL[i], ch_busy_i[i] or ch_wake_i[i] is 1, go to ON.
  - Else if the counter is 0, go to OFF.
  - Otherwise decrement the counter.
- OFF
  - If CTRL[i]=1, go to ON.
  - Else if AUTO[i]=1 and ch_wake_i[i]=1, go to ON and set WAKE_PEND[i].
- clk_en_o[i] is 1 in ON and IDLE and 0 in OFF.

Boundary and corner cases:
- TIMEOUT=0: IDLE→OFF on the first IDLE cycle.
- The counter does not wrap; it saturates at 0.
- ch_busy_i while OFF is ignored; the peripheral is clock-less.
- Clearing AUTO[i] while in IDLE moves the channel to OFF on the next cycle, unless CTRL[i] or ch_busy_i[i] is 1.

## Timing
- Reset values:
  - clk_en_o = all ones.
  - PRDATA = 0.
  - PSLVERR = 0.
  - irq_o = 0.
  - WAKE_PEND = 0.
  - All counters = 0.
- FSM inputs are sampled at a clock edge. The next state and clk_en_o are registered in the same edge, so an input changes clk_en_o after 1 cycle.
- APB write of CTRL: the register updates at edge N and clk_en_o reflects it at edge N+1.
- Automatic gating: OFF is reached TIMEOUT+2 cycles after ch_busy_i falls.
- Simultaneous W1C clear and wake set on the same bit: the set wins.
- Asserting reset mid-operation returns every register and FSM to its reset values immediately.

## Configuration
- APB_CLK_GATE_WAKE_IRQ_EN defined:
  - WAKE_PEND and IRQ_MASK are implemented.
  - irq_o is registered as |(WAKE_PEND & IRQ_MASK).
- Not defined:
  - 0x10 and 0x14 read 0 and ignore writes, without PSLVERR.
  - irq_o is tied to 0.
  - Wake-up gating behaviour is otherwise unchanged.

## Structure
- Package apb_clk_gate_pkg holds:
  - the state enum ch_state_e {CH_ON, CH_IDLE, CH_OFF};
  - the register offset localparams;
  - the reset constants (TIMEOUT_RST = 'h00FF).
- Sub-module clk_gate_ch_fsm contains one channel's FSM plus its CNT_WIDTH counter. It is instantiated NUM_CH times in a generate loop.
- The top level holds the APB decode, the registers and the irq logic.

## Test plan
- Reset release with no APB traffic → clk_en_o = all ones, STATUS reads 0xFF, irq_o = 0.
- Write CTRL=0xFE, AUTO=0 with ch_busy_i[0]=1 for 10 cycles → clk_en_o[0] stays 1 throughout; 0 one cycle after busy falls.
- AUTO=0x04, CTRL=0xFB, TIMEOUT=3, ch_busy_i[2] pulsed then low → clk_en_o[2] drops exactly 5 cycles after busy falls; a busy pulse while in IDLE restarts the count.
- Channel 2 in OFF, IRQ_MASK=0x04, ch_wake_i[2] pulse → clk_en_o[2]=1 next cycle, WAKE_PEND=0x04, irq_o=1. A W1C of 0x04 coinciding with a second wake leaves WAKE_PEND=0x04.
- Read from offset 0x18 → PSLVERR=1, PRDATA=0; a write to 0x18 leaves all registers unchanged.
- Reset asserted in IDLE with counter=2 → clk_en_o returns to all ones asynchronously and AUTO reads 0 after release.
